sevenseg_reader: RTL and testbench

//  Receive side of the 7-segment display interface: samples a multiplexed, active-low segment bus plus

---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/sevenseg_glyph_decode.sv | 35 +++
 rtl/sevenseg_reader.sv | 130 +++++++++++++
 tb/tb_sevenseg_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns (common with the encoder)
// and the reader FSM state encoding.
package sevenseg_pkg;

    // Active-low segment patterns, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational glyph lookup: active-low segment pattern -> hex nibble.
// hit is low when the pattern is not one of the 16 hex glyphs.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] sevenseg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (sevenseg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Receive side of the multiplexed 7-segment bus: filters scan transitions and
// recovers the nibble and decimal point shown on each digit.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              sevenseg,
    input  logic                    decin,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic                    clearerr,
    output logic [4*NUM_DIGITS-1:0] binaryout,
    output logic [NUM_DIGITS-1:0]   decout,
    output logic                    valid,
    output logic [2:0]              digitidx,
    output logic                    error,
    output logic                    errflag,
    output state_t                  dbg_state
);

    // Output protocol: valid and error are one-cycle strobes with no back-pressure
    // (no ready); they never assert together. binaryout/decout hold the last capture.

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
        logic [3:0] zeros;
        zeros = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) zeros = zeros + 4'd1;
        end
        return zeros == 4'd1;
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [SW-1:0] d;
    logic [SW-1:0] s;
    logic [CW-1:0] cnt;
    state_t        state;
    state_t        state_n;
    logic          changed;
    logic          d_active;
    logic          capture;
    logic [2:0]    s_idx;
    logic          hit;
    logic [3:0]    nibble;

    assign d        = {anode, decin, sevenseg};
    assign changed  = (d != s);
    assign d_active = one_low(d[SW-1:8]) && (d[6:0] != SEG_BLANK);
    assign capture  = (state == SETTLE) && (cnt == CNT_MAX);
    assign s_idx    = low_index(s[SW-1:8]);

    sevenseg_glyph_decode u_decode (
        .sevenseg (s[6:0]),
        .hit      (hit),
        .nibble   (nibble)
    );

    // Reset sample is all ones: blank segments, no anode selected
    always_ff @(posedge clk) begin
        if (reset) begin
            s   <= '1;
            cnt <= '0;
        end else begin
            s <= d;
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A capture on the same edge as a change still happens; the change decides the next state
    always_comb begin
        state_n = state;
        if (changed)
            state_n = d_active ? SETTLE : IDLE;
        else if (capture)
            state_n = HELD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            binaryout <= '0;
            decout    <= '0;
            valid     <= 1'b0;
            digitidx  <= '0;
            error     <= 1'b0;
            errflag   <= 1'b0;
        end else begin
            valid <= capture && hit;
            error <= capture && !hit;
            if (capture && hit) begin
                digitidx <= s_idx;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_idx == 3'(i)) begin
                        binaryout[4*i +: 4] <= nibble;
                        decout[i]           <= ~s[7];
                    end
                end
            end
            if (capture && !hit)
                errflag <= 1'b1;
            else if (clearerr)
                errflag <= 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader: directed scenarios plus a randomized run checked
// against a run-length model of the sampled bus.
module tb_sevenseg_reader;
    import sevenseg_pkg::*;

    localparam int ND = 4;
    localparam int SC = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic [6:0]        sevenseg = 7'h7F;
    logic              decin = 1'b1;
    logic [ND-1:0]     anode = '1;
    logic              clearerr = 1'b0;
    logic [4*ND-1:0]   binaryout;
    logic [ND-1:0]     decout;
    logic              valid;
    logic [2:0]        digitidx;
    logic              error;
    logic              errflag;
    state_t            dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    sevenseg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .sevenseg  (sevenseg),
        .decin     (decin),
        .anode     (anode),
        .clearerr  (clearerr),
        .binaryout (binaryout),
        .decout    (decout),
        .valid     (valid),
        .digitidx  (digitidx),
        .error     (error),
        .errflag   (errflag),
        .dbg_state (dbg_state)
    );

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model: last sampled word and how many consecutive edges it was seen
    logic [ND+7:0]   m_last = '1;
    int              m_run = 1;
    logic [4*ND-1:0] m_bin = '0;
    logic [ND-1:0]   m_dec = '0;
    logic            m_valid = 1'b0;
    logic            m_err = 1'b0;
    logic            m_errflag = 1'b0;
    logic [2:0]      m_idx = '0;

    function automatic int low_count(logic [ND+7:0] v);
        int z = 0;
        for (int i = 0; i < ND; i++) if (!v[8+i]) z++;
        return z;
    endfunction

    function automatic int low_digit(logic [ND+7:0] v);
        int dg = 0;
        for (int i = 0; i < ND; i++) if (!v[8+i]) dg = i;
        return dg;
    endfunction

    function automatic int glyph_of(logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyphs[i] == p) return i;
        return -1;
    endfunction

    // advance one clock, then update the model with the word sampled on that edge
    task automatic tick();
        logic [ND+7:0] dw;
        int g;
        int dg;
        @(posedge clk);
        #1;
        dw = {anode, decin, sevenseg};
        if (reset) begin
            m_last = '1; m_run = 1; m_bin = '0; m_dec = '0;
            m_valid = 1'b0; m_err = 1'b0; m_errflag = 1'b0; m_idx = '0;
        end else begin
            m_valid = 1'b0;
            m_err = 1'b0;
            if (m_run == SC && low_count(m_last) == 1 && m_last[6:0] != 7'h7F) begin
                g = glyph_of(m_last[6:0]);
                dg = low_digit(m_last);
                if (g >= 0) begin
                    m_bin[4*dg +: 4] = 4'(g);
                    m_dec[dg] = ~m_last[7];
                    m_idx = 3'(dg);
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_err) m_errflag = 1'b1;
            else if (clearerr) m_errflag = 1'b0;
            if (dw == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_last = dw;
                m_run = 1;
            end
        end
    endtask

    task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input logic dp);
        anode = an;
        sevenseg = seg;
        decin = dp;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive('1, 7'h7F, 1'b1);
        tick();
        tick();
        tests_run++; if (binaryout !== '0) begin tests_failed++; $display("FAIL reset_binaryout got %h want 0", binaryout); end
        tests_run++; if (decout !== '0) begin tests_failed++; $display("FAIL reset_decout got %b want 0", decout); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid); end
        tests_run++; if (digitidx !== 3'd0) begin tests_failed++; $display("FAIL reset_digitidx got %0d want 0", digitidx); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b want 0", error); end
        tests_run++; if (errflag !== 1'b0) begin tests_failed++; $display("FAIL reset_errflag got %b want 0", errflag); end
        tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_digit();
        int vcnt = 0;
        drive(4'b1110, 7'h24, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests_run++;
            if (valid !== (i == 5)) begin tests_failed++; $display("FAIL single_latency edge E+%0d valid got %b want %b", i - 1, valid, i == 5); end
            if (valid) begin
                vcnt++;
                tests_run++; if (binaryout[3:0] !== 4'h2) begin tests_failed++; $display("FAIL single_nibble got %h want 2", binaryout[3:0]); end
                tests_run++; if (digitidx !== 3'd0) begin tests_failed++; $display("FAIL single_idx got %0d want 0", digitidx); end
            end
        end
        tests_run++; if (vcnt != 1) begin tests_failed++; $display("FAIL single_count got %0d want 1", vcnt); end
        drive('1, 7'h7F, 1'b1);
        tick(); tick();
    endtask

    task automatic test_scan();
        logic [3:0] vals [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
        int vcnt = 0;
        for (int dg = 3; dg >= 0; dg--) begin
            drive(~(4'b0001 << dg), glyphs[vals[dg]], (dg == 2) ? 1'b0 : 1'b1);
            for (int c = 0; c < 8; c++) begin
                tick();
                if (valid) begin
                    vcnt++;
                    tests_run++; if (digitidx !== 3'(dg)) begin tests_failed++; $display("FAIL scan_idx got %0d want %0d", digitidx, dg); end
                end
            end
        end
        tests_run++; if (binaryout !== 16'h1A3F) begin tests_failed++; $display("FAIL scan_binaryout got %h want 1a3f", binaryout); end
        tests_run++; if (decout !== 4'b0100) begin tests_failed++; $display("FAIL scan_decout got %b want 0100", decout); end
        tests_run++; if (vcnt != 4) begin tests_failed++; $display("FAIL scan_valid_count got %0d want 4", vcnt); end
    endtask

    task automatic test_glitch();
        int vcnt = 0;
        int ecnt = 0;
        drive('1, 7'h7F, 1'b1);
        tick(); tick();
        drive(4'b1101, 7'h00, 1'b1);
        for (int c = 0; c < 11; c++) begin
            if (c == 3) sevenseg = 7'h40;
            tick();
            if (valid) vcnt++;
            if (error) ecnt++;
        end
        tests_run++; if (vcnt != 1) begin tests_failed++; $display("FAIL glitch_valid_count got %0d want 1", vcnt); end
        tests_run++; if (ecnt != 0) begin tests_failed++; $display("FAIL glitch_error_count got %0d want 0", ecnt); end
        tests_run++; if (binaryout !== 16'h1A0F) begin tests_failed++; $display("FAIL glitch_binaryout got %h want 1a0f", binaryout); end
    endtask

    task automatic test_illegal();
        int vcnt = 0;
        int ecnt = 0;
        drive(4'b1101, 7'h7E, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid) vcnt++;
            if (error) ecnt++;
        end
        tests_run++; if (ecnt != 1) begin tests_failed++; $display("FAIL illegal_error_count got %0d want 1", ecnt); end
        tests_run++; if (vcnt != 0) begin tests_failed++; $display("FAIL illegal_valid_count got %0d want 0", vcnt); end
        tests_run++; if (errflag !== 1'b1) begin tests_failed++; $display("FAIL illegal_errflag got %b want 1", errflag); end
        tests_run++; if (binaryout !== 16'h1A0F) begin tests_failed++; $display("FAIL illegal_binaryout got %h want 1a0f", binaryout); end
        clearerr = 1'b1;
        tick();
        clearerr = 1'b0;
        tests_run++; if (errflag !== 1'b0) begin tests_failed++; $display("FAIL illegal_clearerr got %b want 0", errflag); end
        // error coinciding with clearerr keeps the flag set
        ecnt = 0;
        drive(4'b1011, 7'h7E, 1'b1);
        clearerr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (error) begin
                ecnt++;
                tests_run++; if (errflag !== 1'b1) begin tests_failed++; $display("FAIL illegal_error_wins got %b want 1", errflag); end
            end
        end
        tests_run++; if (ecnt != 1) begin tests_failed++; $display("FAIL illegal_error2_count got %0d want 1", ecnt); end
        tests_run++; if (errflag !== 1'b0) begin tests_failed++; $display("FAIL illegal_clear_after got %b want 0", errflag); end
        clearerr = 1'b0;
        drive('1, 7'h7F, 1'b1);
        tick();
    endtask

    task automatic test_idle_patterns();
        int vcnt = 0;
        int ecnt = 0;
        drive(4'b1100, 7'h24, 1'b1);
        for (int c = 0; c < 10; c++) begin tick(); if (valid) vcnt++; if (error) ecnt++; end
        drive(4'b1110, 7'h7F, 1'b0);
        for (int c = 0; c < 10; c++) begin tick(); if (valid) vcnt++; if (error) ecnt++; end
        tests_run++; if (vcnt != 0) begin tests_failed++; $display("FAIL idle_valid_count got %0d want 0", vcnt); end
        tests_run++; if (ecnt != 0) begin tests_failed++; $display("FAIL idle_error_count got %0d want 0", ecnt); end
        tests_run++; if (binaryout !== 16'h1A0F) begin tests_failed++; $display("FAIL idle_binaryout got %h want 1a0f", binaryout); end
    endtask

    task automatic test_reset_mid_settle();
        int vcnt = 0;
        drive('1, 7'h7F, 1'b1);
        tick(); tick();
        drive(4'b1110, 7'h30, 1'b1);
        for (int c = 0; c < 3; c++) begin tick(); if (valid) vcnt++; end
        reset = 1'b1;
        tick();
        if (valid) vcnt++;
        tests_run++; if (vcnt != 0) begin tests_failed++; $display("FAIL rstmid_valid_count got %0d want 0", vcnt); end
        tests_run++; if (binaryout !== '0) begin tests_failed++; $display("FAIL rstmid_binaryout got %h want 0", binaryout); end
        tests_run++; if (decout !== '0) begin tests_failed++; $display("FAIL rstmid_decout got %b want 0", decout); end
        tests_run++; if (errflag !== 1'b0 || error !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err got %b/%b want 0/0", error, errflag); end
        tests_run++; if (digitidx !== 3'd0) begin tests_failed++; $display("FAIL rstmid_digitidx got %0d want 0", digitidx); end
        reset = 1'b0;
        drive('1, 7'h7F, 1'b1);
        tick();
    endtask

    task automatic test_random();
        int cycles = 0;
        int r;
        int len;
        logic [6:0] seg;
        logic [ND-1:0] an;
        while (cycles < 1500) begin
            r = $urandom_range(0, 9);
            if (r < 6) seg = glyphs[$urandom_range(0, 15)];
            else if (r < 8) seg = 7'($urandom_range(0, 127));
            else seg = 7'h7F;
            if ($urandom_range(0, 4) != 0) an = ~(4'b0001 << $urandom_range(0, ND - 1));
            else an = 4'($urandom_range(0, 15));
            drive(an, seg, 1'($urandom_range(0, 1)));
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                clearerr = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 199) == 0);
                tick();
                cycles++;
                tests_run++; if (valid !== m_valid) begin tests_failed++; $display("FAIL rand_valid cyc %0d got %b want %b", cycles, valid, m_valid); end
                tests_run++; if (error !== m_err) begin tests_failed++; $display("FAIL rand_error cyc %0d got %b want %b", cycles, error, m_err); end
                tests_run++; if (errflag !== m_errflag) begin tests_failed++; $display("FAIL rand_errflag cyc %0d got %b want %b", cycles, errflag, m_errflag); end
                tests_run++; if (binaryout !== m_bin) begin tests_failed++; $display("FAIL rand_binaryout cyc %0d got %h want %h", cycles, binaryout, m_bin); end
                tests_run++; if (decout !== m_dec) begin tests_failed++; $display("FAIL rand_decout cyc %0d got %b want %b", cycles, decout, m_dec); end
                if (m_valid) begin
                    tests_run++; if (digitidx !== m_idx) begin tests_failed++; $display("FAIL rand_digitidx cyc %0d got %0d want %0d", cycles, digitidx, m_idx); end
                end
            end
        end
        reset = 1'b0;
        clearerr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_scan();
        test_glitch();
        test_illegal();
        test_idle_patterns();
        test_reset_mid_settle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
